adpll_fll_ctrl: RTL
===================

ADPLL_FLL_CTRL -- requirements
Module: adpll_fll_ctrl

Interface
- REQ-001 SHALL have parameter CODE_W, default 10: DCO control word width.
- REQ-002 SHALL have parameter CNT_W, default 11: target/measured count width.
- REQ-003 SHALL have parameter FRAC_W, default 8: fractional target width.
- REQ-004 SHALL have parameter LOCK_CNT, default 10: consecutive in-tolerance measurements needed to assert lock.
- REQ-005 SHALL have parameter LOCK_TOL, default 1: in-tolerance bound, |err| <= LOCK_TOL.
- REQ-006 SHALL have parameter UNLOCK_CNT, default 4: consecutive out-of-tolerance measurements that drop lock.
- REQ-007 SHALL have parameter RELOCK_THR, default 16: |err| above this while locked restarts coarse search.
- REQ-008 SHALL have port REF_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-009 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
- REQ-010 SHALL have port EN, input, 1 bit: loop enable.
- REQ-011 SHALL have port N_INTEGER, input, CNT_W bits: integer target DCO cycles per REF_CLK period.
- REQ-012 SHALL have port F_FRACTION, input, FRAC_W bits: fractional target in units of 2^-FRAC_W.
- REQ-013 SHALL have port DCO_CNT, input, CNT_W bits: DCO cycles counted over the previous REF_CLK period, already in the REF_CLK domain.
- REQ-014 SHALL have port DCO_CNT_VLD, input, 1 bit: DCO_CNT is valid this cycle (one measurement).
- REQ-015 SHALL have port DCO_CODE, output, CODE_W bits: DCO control word; larger code means lower frequency.
- REQ-016 SHALL have port ADPLL_LOCK, output, 1 bit: lock indicator.
- REQ-017 SHALL have port LOCK_LOST, output, 1 bit: one-cycle pulse when lock drops.
- REQ-018 SHALL have port STATE, output, 2 bits: current FSM state.

Function
- REQ-019 SHALL implement FSM states IDLE=0, COARSE=1, FINE=2, LOCKED=3, and SHALL advance only on cycles with DCO_CNT_VLD=1, except for EN.
- REQ-020 SHALL, in IDLE with EN=1, capture N_INTEGER and F_FRACTION, set DCO_CODE to 1 followed by zeros (MSB only), set bit index to CODE_W-1, and enter COARSE on the next cycle; captured targets SHALL be held until the next IDLE exit.
- REQ-021 SHALL compute err = DCO_CNT - target as a signed value of CNT_W+2 bits.
- REQ-022 SHALL, in COARSE (SAR), on each measurement keep the current bit when err>0 and clear it otherwise, then set the next lower bit; after bit 0 is decided SHALL enter FINE; COARSE SHALL last exactly CODE_W measurements.
- REQ-023 SHALL, in FINE and LOCKED, leave DCO_CODE unchanged when |err| <= LOCK_TOL, and otherwise add 1 when err>0 or subtract 1 when err<0.
- REQ-024 SHALL saturate DCO_CODE at 0 and at 2^CODE_W-1 with no wrap.
- REQ-025 SHALL, in FINE, count consecutive in-tolerance measurements, reset that count on any miss, and on reaching LOCK_CNT enter LOCKED and assert ADPLL_LOCK in the same cycle as the transition.
- REQ-026 SHALL, in LOCKED, count consecutive out-of-tolerance measurements; on reaching UNLOCK_CNT it SHALL clear ADPLL_LOCK, pulse LOCK_LOST for one cycle and enter FINE.
- REQ-027 SHALL, in LOCKED, treat |err| > RELOCK_THR as an immediate exit: clear lock, pulse LOCK_LOST, and restart COARSE from mid-scale; this check SHALL take priority over REQ-026.
- REQ-028 SHALL, whenever EN=0 in any state, enter IDLE on the next cycle, clear ADPLL_LOCK and all counters, and hold DCO_CODE; LOCK_LOST SHALL pulse if ADPLL_LOCK was 1.
- REQ-029 SHALL ignore DCO_CNT_VLD while in IDLE.

Reset
- REQ-030 SHALL, while RESET=0, force STATE=IDLE, DCO_CODE to 1 followed by zeros (MSB only), ADPLL_LOCK=0, LOCK_LOST=0, and clear all counters and the accumulator, asynchronously; reset mid-search SHALL abandon the search.

Configuration
- REQ-031 SHALL, with ADPLL_FRAC_EN defined, run an FRAC_W-bit accumulator that adds F_FRACTION on each valid measurement; target SHALL be N_INTEGER+carry for that measurement, and the accumulator SHALL clear on IDLE exit.
- REQ-032 SHALL, with ADPLL_FRAC_EN undefined, use target = N_INTEGER, keep the F_FRACTION port present but ignored, and contain no accumulator logic.

Structure
- REQ-033 SHALL use package adpll_pkg for the state enum, state encodings and the default parameter constants.
- REQ-034 SHALL place the SAR bit-decision logic (code register, bit index, done flag) in sub-module adpll_sar.

Verification
- REQ-035 SHALL cover: reset with EN=0 -> DCO_CODE=0x200, STATE=0, ADPLL_LOCK=0.
- REQ-036 SHALL cover: DCO model cnt=1100-code, N=700, EN=1 -> 10 COARSE measurements end at code 399 or 400, then lock after 10 measurements with |err|<=1.
- REQ-037 SHALL cover: from lock, model shifted +3 counts for 4 measurements -> LOCK_LOST one-cycle pulse, STATE=FINE, code tracks +1 per measurement.
- REQ-038 SHALL cover: from lock, model shifted +40 -> single-measurement exit to COARSE, DCO_CODE=0x200.
- REQ-039 SHALL cover: target beyond range (N=2000) -> DCO_CODE saturates at 0 with no wrap and lock never asserts.
- REQ-040 SHALL cover: ADPLL_FRAC_EN defined with N=700, F=0x80 -> target alternates 700/701, mean measured count over 256 measurements = 700.5 +/- 0.05; and EN dropped mid-COARSE -> IDLE next cycle with no LOCK_LOST pulse.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared types and default constants for the ADPLL frequency-locked-loop controller.
package adpll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COARSE = 2'd1,
      ST_FINE   = 2'd2,
      ST_LOCKED = 2'd3
   } adpll_state_e;

   localparam int DEF_CODE_W     = 10;
   localparam int DEF_CNT_W      = 11;
   localparam int DEF_FRAC_W     = 8;
   localparam int DEF_LOCK_CNT   = 10;
   localparam int DEF_LOCK_TOL   = 1;
   localparam int DEF_UNLOCK_CNT = 4;
   localparam int DEF_RELOCK_THR = 16;

endpackage

// File: rtl/adpll_sar.sv
// DCO code register: successive-approximation search plus saturating +/-1 trim.
module adpll_sar
   import adpll_pkg::*;
#(
   parameter int CODE_W = DEF_CODE_W
) (
   input  logic              clk_sys,
   input  logic              rst_b,
   input  logic              init_i,     // load mid-scale, restart search at MSB
   input  logic              step_i,     // one SAR decision this cycle
   input  logic              keep_i,     // keep the bit under test
   input  logic              trim_up_i,
   input  logic              trim_dn_i,
   output logic [CODE_W-1:0] code_o,
   output logic              done_o      // high on the step that decides bit 0
);

   localparam int                IDX_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [CODE_W-1:0] MID     = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [CODE_W-1:0] MAX     = '1;
   localparam logic [IDX_W-1:0]  MSB_IDX = IDX_W'(CODE_W - 1);

   logic [CODE_W-1:0] code_q, code_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              done_q, done_d;

   // bit decision, then arm the next lower bit; trim only outside a running search
   always_comb begin
      code_d = code_q;
      idx_d  = idx_q;
      done_d = done_q;
      if (init_i) begin
         code_d = MID;
         idx_d  = MSB_IDX;
         done_d = 1'b0;
      end else if (step_i && !done_q) begin
         if (!keep_i) code_d[idx_q] = 1'b0;
         if (idx_q == '0) begin
            done_d = 1'b1;
         end else begin
            idx_d         = idx_q - IDX_W'(1);
            code_d[idx_d] = 1'b1;
         end
      end else if (trim_up_i && (code_q != MAX)) begin
         code_d = code_q + CODE_W'(1);
      end else if (trim_dn_i && (code_q != '0)) begin
         code_d = code_q - CODE_W'(1);
      end
   end

   // code/index/done registers
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         code_q <= MID;
         idx_q  <= MSB_IDX;
         done_q <= 1'b0;
      end else begin
         code_q <= code_d;
         idx_q  <= idx_d;
         done_q <= done_d;
      end
   end

   assign code_o = code_q;
   assign done_o = step_i && !done_q && (idx_q == '0);

endmodule

// File: rtl/adpll_fll_ctrl.sv
// ADPLL frequency-locked-loop controller: SAR coarse search, +/-1 fine tracking,
// lock/unlock detection. Define ADPLL_FRAC_EN to add fractional-N target dithering.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | loop disabled; code held; on EN capture targets, load mid-scale
// COARSE    | SAR search, one code bit decided per measurement, MSB first
// FINE      | +/-1 tracking, counting consecutive in-tolerance measurements
// LOCKED    | lock asserted, tracking, counting consecutive misses
module adpll_fll_ctrl
   import adpll_pkg::*;
#(
   parameter int CODE_W     = DEF_CODE_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int FRAC_W     = DEF_FRAC_W,
   parameter int LOCK_CNT   = DEF_LOCK_CNT,
   parameter int LOCK_TOL   = DEF_LOCK_TOL,
   parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
   parameter int RELOCK_THR = DEF_RELOCK_THR
) (
   input  logic              REF_CLK,
   input  logic              RESET,
   input  logic              EN,
   input  logic [CNT_W-1:0]  N_INTEGER,
   input  logic [FRAC_W-1:0] F_FRACTION,
   input  logic [CNT_W-1:0]  DCO_CNT,
   input  logic              DCO_CNT_VLD,
   output logic [CODE_W-1:0] DCO_CODE,
   output logic              ADPLL_LOCK,
   output logic              LOCK_LOST,
   output logic [1:0]        STATE
);

   localparam int ERR_W  = CNT_W + 2;
   localparam int HIT_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

   adpll_state_e      state_q, state_d;
   logic              lock_q, lock_d;
   logic              lost_q, lost_d;
   logic [HIT_W-1:0]  hit_q, hit_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic [CNT_W-1:0]  n_tgt_q, n_tgt_d;
   logic [CNT_W:0]    target;

   logic              sar_init, sar_step, sar_done, trim_up, trim_dn;
   logic [CODE_W-1:0] sar_code;

   logic signed [ERR_W-1:0] err;
   logic [ERR_W-1:0]        err_abs;
   logic                    err_pos, err_neg, in_tol, far_off;

`ifdef ADPLL_FRAC_EN
   logic [FRAC_W-1:0] frac_q, frac_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [FRAC_W:0]   acc_sum;

   assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
   assign target  = {1'b0, n_tgt_q} + {{CNT_W{1'b0}}, acc_sum[FRAC_W]};

   // fraction captured on IDLE exit; accumulator parked at zero in IDLE
   always_comb begin
      frac_d = frac_q;
      acc_d  = acc_q;
      if (state_q == ST_IDLE) begin
         acc_d = '0;
         if (EN) frac_d = F_FRACTION;
      end else if (EN && DCO_CNT_VLD) begin
         acc_d = acc_sum[FRAC_W-1:0];
      end
   end

   // fractional accumulator registers
   always_ff @(posedge REF_CLK or negedge RESET) begin
      if (!RESET) begin
         frac_q <= '0;
         acc_q  <= '0;
      end else begin
         frac_q <= frac_d;
         acc_q  <= acc_d;
      end
   end
`else
   logic unused_frac;
   assign unused_frac = ^F_FRACTION;
   assign target      = {1'b0, n_tgt_q};
`endif

   // frequency error, positive means the DCO runs fast
   assign err     = $signed({2'b00, DCO_CNT}) - $signed({1'b0, target});
   assign err_abs = err[ERR_W-1] ? $unsigned(-err) : $unsigned(err);
   assign err_neg = err[ERR_W-1];
   assign err_pos = !err[ERR_W-1] && (err != '0);
   assign in_tol  = (err_abs <= ERR_W'(LOCK_TOL));
   assign far_off = (err_abs > ERR_W'(RELOCK_THR));

   adpll_sar #(.CODE_W(CODE_W)) u_sar (
      .clk_sys   (REF_CLK),
      .rst_b     (RESET),
      .init_i    (sar_init),
      .step_i    (sar_step),
      .keep_i    (err_pos),
      .trim_up_i (trim_up),
      .trim_dn_i (trim_dn),
      .code_o    (sar_code),
      .done_o    (sar_done)
   );

   // next-state, lock bookkeeping and code-register commands
   always_comb begin
      state_d  = state_q;
      lock_d   = lock_q;
      lost_d   = 1'b0;
      hit_d    = hit_q;
      miss_d   = miss_q;
      n_tgt_d  = n_tgt_q;
      sar_init = 1'b0;
      sar_step = 1'b0;
      trim_up  = 1'b0;
      trim_dn  = 1'b0;
      if (!EN) begin
         state_d = ST_IDLE;
         lock_d  = 1'b0;
         lost_d  = lock_q;
         hit_d   = '0;
         miss_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               n_tgt_d  = N_INTEGER;
               sar_init = 1'b1;
               hit_d    = '0;
               miss_d   = '0;
               state_d  = ST_COARSE;
            end
            ST_COARSE: begin
               if (DCO_CNT_VLD) begin
                  sar_step = 1'b1;
                  if (sar_done) begin
                     state_d = ST_FINE;
                     hit_d   = '0;
                  end
               end
            end
            ST_FINE: begin
               if (DCO_CNT_VLD) begin
                  trim_up = !in_tol && err_pos;
                  trim_dn = !in_tol && err_neg;
                  if (!in_tol) begin
                     hit_d = '0;
                  end else if (hit_q == HIT_W'(LOCK_CNT - 1)) begin
                     state_d = ST_LOCKED;
                     lock_d  = 1'b1;
                     hit_d   = '0;
                     miss_d  = '0;
                  end else begin
                     hit_d = hit_q + HIT_W'(1);
                  end
               end
            end
            ST_LOCKED: begin
               if (DCO_CNT_VLD) begin
                  if (far_off) begin
                     // gross error: abandon tracking and search again from mid-scale
                     state_d  = ST_COARSE;
                     lock_d   = 1'b0;
                     lost_d   = 1'b1;
                     sar_init = 1'b1;
                     miss_d   = '0;
                  end else begin
                     trim_up = !in_tol && err_pos;
                     trim_dn = !in_tol && err_neg;
                     if (in_tol) begin
                        miss_d = '0;
                     end else if (miss_q == MISS_W'(UNLOCK_CNT - 1)) begin
                        state_d = ST_FINE;
                        lock_d  = 1'b0;
                        lost_d  = 1'b1;
                        miss_d  = '0;
                        hit_d   = '0;
                     end else begin
                        miss_d = miss_q + MISS_W'(1);
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM and status registers
   always_ff @(posedge REF_CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         lock_q  <= 1'b0;
         lost_q  <= 1'b0;
         hit_q   <= '0;
         miss_q  <= '0;
         n_tgt_q <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         lost_q  <= lost_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         n_tgt_q <= n_tgt_d;
      end
   end

   assign DCO_CODE   = sar_code;
   assign ADPLL_LOCK = lock_q;
   assign LOCK_LOST  = lost_q;
   assign STATE      = state_q;

endmodule
